// File: rtl/dcache_refill_pkg.sv
// Shared widths, FSM encoding and miss payload for the dcache refill engine.
package dcache_refill_pkg;

    localparam int unsigned TAG_WIDTH      = 19;
    localparam int unsigned IDX_WIDTH      = 8;
    localparam int unsigned LINE_WIDTH     = 256;
    localparam int unsigned BUS_WIDTH      = 64;
    localparam int unsigned BEATS          = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned BEAT_CNT_WIDTH = $clog2(BEATS);
    localparam int unsigned OFF_WIDTH      = $clog2(LINE_WIDTH / 8);
    localparam int unsigned ADDR_WIDTH     = TAG_WIDTH + IDX_WIDTH + OFF_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_WRITE = 2'd3
    } refill_state_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [IDX_WIDTH-1:0] idx;
    } miss_req_t;

    // Line-aligned bus address of a missing line.
    function automatic logic [ADDR_WIDTH-1:0] line_addr(input miss_req_t m);
        return {m.tag, m.idx, OFF_WIDTH'(0)};
    endfunction

endpackage

// File: rtl/dcache_refill_module_line_buf.sv
// Beat-indexed assembly buffer: beat 0 lands in the line LSBs.
module dcache_line_buf_module
    import dcache_refill_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [BEAT_CNT_WIDTH-1:0] beat_cnt,
    input  logic [BUS_WIDTH-1:0]      beat_dat,
    output logic [LINE_WIDTH-1:0]     line
);

    logic [BEATS-1:0][BUS_WIDTH-1:0] beats_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beats_q <= '0;
        end else if (we) begin
            beats_q[beat_cnt] <= beat_dat;
        end
    end

    assign line = beats_q;

endmodule

// File: rtl/dcache_refill_module.sv
// Blocking single-outstanding dcache miss refill engine: bus read, beat assembly, one-cycle line write.
module dcache_refill_module
    import dcache_refill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_miss_vld,
    input  logic [TAG_WIDTH-1:0]  i_miss_tag,
    input  logic [IDX_WIDTH-1:0]  i_miss_idx,
    output logic                  o_miss_rdy,
    input  logic                  i_flush,
    output logic                  o_mem_req_vld,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_req_rdy,
    input  logic                  i_mem_resp_vld,
    input  logic [BUS_WIDTH-1:0]  i_mem_resp_dat,
    input  logic                  i_mem_resp_err,
    output logic                  o_dcache_wren,
    output logic [IDX_WIDTH-1:0]  o_dcache_widx,
    output logic [TAG_WIDTH-1:0]  o_dcache_wtag,
    output logic [LINE_WIDTH-1:0] o_dcache_wdat,
    output logic                  o_refill_busy,
    output logic [IDX_WIDTH-1:0]  o_refill_idx,
    output logic                  o_refill_done,
    output logic                  o_refill_err
);

    refill_state_e             state_q, state_d;
    miss_req_t                 miss_q, miss_d;
    logic                      err_q, err_d;
    logic                      kill_q, kill_d;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                      beat_we_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            miss_q     <= '0;
            err_q      <= 1'b0;
            kill_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            kill_q     <= kill_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        miss_d        = miss_q;
        err_d         = err_q;
        kill_d        = kill_q;
        beat_cnt_d    = beat_cnt_q;
        beat_we_c     = 1'b0;
        o_miss_rdy    = 1'b0;
        o_mem_req_vld = 1'b0;
        o_dcache_wren = 1'b0;
        o_refill_done = 1'b0;
        o_refill_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_miss_rdy = 1'b1;
                if (i_miss_vld) begin
                    miss_d.tag = i_miss_tag;
                    miss_d.idx = i_miss_idx;
                    err_d      = 1'b0;
                    kill_d     = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_vld = 1'b1;
                if (i_mem_req_rdy) begin
                    // Once accepted the bus will return beats; drain them even if flushed.
                    state_d = S_RESP;
                    if (i_flush) begin
                        kill_d = 1'b1;
                    end
                end else if (i_flush) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (i_flush) begin
                    kill_d = 1'b1;
                end
                if (i_mem_resp_vld) begin
                    beat_we_c  = 1'b1;
                    beat_cnt_d = BEAT_CNT_WIDTH'(beat_cnt_q + 1'b1);
                    err_d      = err_q | i_mem_resp_err;
                    if (beat_cnt_q == BEAT_CNT_WIDTH'(BEATS - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                o_dcache_wren = !err_q && !kill_q && !i_flush;
                o_refill_done = !kill_q && !i_flush;
                o_refill_err  = err_q && !kill_q && !i_flush;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    dcache_line_buf_module u_line_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (beat_we_c),
        .beat_cnt (beat_cnt_q),
        .beat_dat (i_mem_resp_dat),
        .line     (o_dcache_wdat)
    );

    assign o_mem_req_addr = line_addr(miss_q);
    assign o_dcache_widx  = miss_q.idx;
    assign o_dcache_wtag  = miss_q.tag;
    assign o_refill_busy  = (state_q != S_IDLE);
    assign o_refill_idx   = miss_q.idx;

    // Beats are only legal while a request is outstanding.
    resp_only_in_resp_a: assert property (@(posedge clk) disable iff (!rst_n)
        i_mem_resp_vld |-> (state_q == S_RESP));

endmodule

// File: tb/tb_dcache_refill_module.sv
// Directed self-checking bench for dcache_refill_module.
module tb_dcache_refill_module;
    import dcache_refill_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_miss_vld;
    logic [TAG_WIDTH-1:0]  i_miss_tag;
    logic [IDX_WIDTH-1:0]  i_miss_idx;
    logic                  o_miss_rdy;
    logic                  i_flush;
    logic                  o_mem_req_vld;
    logic [ADDR_WIDTH-1:0] o_mem_req_addr;
    logic                  i_mem_req_rdy;
    logic                  i_mem_resp_vld;
    logic [BUS_WIDTH-1:0]  i_mem_resp_dat;
    logic                  i_mem_resp_err;
    logic                  o_dcache_wren;
    logic [IDX_WIDTH-1:0]  o_dcache_widx;
    logic [TAG_WIDTH-1:0]  o_dcache_wtag;
    logic [LINE_WIDTH-1:0] o_dcache_wdat;
    logic                  o_refill_busy;
    logic [IDX_WIDTH-1:0]  o_refill_idx;
    logic                  o_refill_done;
    logic                  o_refill_err;

    int checks   = 0;
    int failures = 0;

    dcache_refill_module dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss_vld     (i_miss_vld),
        .i_miss_tag     (i_miss_tag),
        .i_miss_idx     (i_miss_idx),
        .o_miss_rdy     (o_miss_rdy),
        .i_flush        (i_flush),
        .o_mem_req_vld  (o_mem_req_vld),
        .o_mem_req_addr (o_mem_req_addr),
        .i_mem_req_rdy  (i_mem_req_rdy),
        .i_mem_resp_vld (i_mem_resp_vld),
        .i_mem_resp_dat (i_mem_resp_dat),
        .i_mem_resp_err (i_mem_resp_err),
        .o_dcache_wren  (o_dcache_wren),
        .o_dcache_widx  (o_dcache_widx),
        .o_dcache_wtag  (o_dcache_wtag),
        .o_dcache_wdat  (o_dcache_wdat),
        .o_refill_busy  (o_refill_busy),
        .o_refill_idx   (o_refill_idx),
        .o_refill_done  (o_refill_done),
        .o_refill_err   (o_refill_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs may be driven and state-decoded outputs sampled afterwards.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic start_miss(input logic [TAG_WIDTH-1:0] t, input logic [IDX_WIDTH-1:0] x);
        i_miss_vld = 1'b1;
        i_miss_tag = t;
        i_miss_idx = x;
        cyc();
        i_miss_vld = 1'b0;
    endtask

    task automatic grant_req();
        i_mem_req_rdy = 1'b1;
        cyc();
        i_mem_req_rdy = 1'b0;
    endtask

    task automatic beat(input logic [BUS_WIDTH-1:0] d, input logic e);
        i_mem_resp_vld = 1'b1;
        i_mem_resp_dat = d;
        i_mem_resp_err = e;
        cyc();
        i_mem_resp_vld = 1'b0;
        i_mem_resp_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_miss_vld = 1'b0; i_miss_tag = '0; i_miss_idx = '0;
        i_flush = 1'b0; i_mem_req_rdy = 1'b0;
        i_mem_resp_vld = 1'b0; i_mem_resp_dat = '0; i_mem_resp_err = 1'b0;
        cyc(); cyc();

        chk("rst_miss_rdy", 256'(o_miss_rdy), 256'(1'b1));
        chk("rst_req_vld",  256'(o_mem_req_vld), 256'(1'b0));
        chk("rst_addr",     256'(o_mem_req_addr), 256'(32'h0));
        chk("rst_busy",     256'(o_refill_busy), 256'(1'b0));
        chk("rst_wren",     256'(o_dcache_wren), 256'(1'b0));
        chk("rst_wdat",     o_dcache_wdat, 256'h0);
        rst_n = 1'b1;
        cyc();

        // Basic refill
        start_miss(19'h1A2B3, 8'h45);
        chk("t1_req_vld",  256'(o_mem_req_vld), 256'(1'b1));
        chk("t1_addr",     256'(o_mem_req_addr), 256'(32'h3456_68A0));
        chk("t1_miss_rdy", 256'(o_miss_rdy), 256'(1'b0));
        chk("t1_busy",     256'(o_refill_busy), 256'(1'b1));
        chk("t1_ridx",     256'(o_refill_idx), 256'(8'h45));
        grant_req();
        chk("t1_req_drop", 256'(o_mem_req_vld), 256'(1'b0));
        beat(64'h1111_1111_1111_1111, 1'b0);
        beat(64'h2222_2222_2222_2222, 1'b0);
        beat(64'h3333_3333_3333_3333, 1'b0);
        chk("t1_no_early_wren", 256'(o_dcache_wren), 256'(1'b0));
        beat(64'h4444_4444_4444_4444, 1'b0);
        chk("t1_wren", 256'(o_dcache_wren), 256'(1'b1));
        chk("t1_done", 256'(o_refill_done), 256'(1'b1));
        chk("t1_err",  256'(o_refill_err), 256'(1'b0));
        chk("t1_widx", 256'(o_dcache_widx), 256'(8'h45));
        chk("t1_wtag", 256'(o_dcache_wtag), 256'(19'h1A2B3));
        chk("t1_wdat", o_dcache_wdat,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        cyc();
        chk("t1_wren_once", 256'(o_dcache_wren), 256'(1'b0));
        chk("t1_done_once", 256'(o_refill_done), 256'(1'b0));
        chk("t1_idle_rdy",  256'(o_miss_rdy), 256'(1'b1));
        chk("t1_idle_busy", 256'(o_refill_busy), 256'(1'b0));

        // Back-pressure, beat gap, max tag/idx
        start_miss(19'h7FFFF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            chk("t2_req_hold",  256'(o_mem_req_vld), 256'(1'b1));
            chk("t2_addr_hold", 256'(o_mem_req_addr), 256'(32'hFFFF_FFE0));
            chk("t2_miss_rdy",  256'(o_miss_rdy), 256'(1'b0));
            cyc();
        end
        chk("t2_req_still", 256'(o_mem_req_vld), 256'(1'b1));
        grant_req();
        beat(64'hA0A0_A0A0_A0A0_A0A0, 1'b0);
        beat(64'hB1B1_B1B1_B1B1_B1B1, 1'b0);
        cyc();
        chk("t2_gap_busy", 256'(o_refill_busy), 256'(1'b1));
        chk("t2_gap_wren", 256'(o_dcache_wren), 256'(1'b0));
        beat(64'hC2C2_C2C2_C2C2_C2C2, 1'b0);
        beat(64'hD3D3_D3D3_D3D3_D3D3, 1'b0);
        chk("t2_wren", 256'(o_dcache_wren), 256'(1'b1));
        chk("t2_wtag", 256'(o_dcache_wtag), 256'(19'h7FFFF));
        chk("t2_widx", 256'(o_dcache_widx), 256'(8'hFF));
        chk("t2_wdat", o_dcache_wdat,
            256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0);
        chk("t2_miss_rdy_write", 256'(o_miss_rdy), 256'(1'b0));
        cyc();
        chk("t2_wren_once", 256'(o_dcache_wren), 256'(1'b0));
        chk("t2_idle_rdy",  256'(o_miss_rdy), 256'(1'b1));

        // Bus error on beat 2
        start_miss(19'h00001, 8'h00);
        chk("t3_addr", 256'(o_mem_req_addr), 256'(32'h0000_2000));
        grant_req();
        beat(64'h1, 1'b0);
        beat(64'h2, 1'b0);
        beat(64'h3, 1'b1);
        beat(64'h4, 1'b0);
        chk("t3_wren", 256'(o_dcache_wren), 256'(1'b0));
        chk("t3_done", 256'(o_refill_done), 256'(1'b1));
        chk("t3_err",  256'(o_refill_err), 256'(1'b1));
        cyc();
        chk("t3_err_pulse", 256'(o_refill_err), 256'(1'b0));

        // Flush in REQ without grant withdraws the request
        start_miss(19'h0ABCD, 8'h33);
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        chk("t4a_rdy",     256'(o_miss_rdy), 256'(1'b1));
        chk("t4a_busy",    256'(o_refill_busy), 256'(1'b0));
        chk("t4a_req_vld", 256'(o_mem_req_vld), 256'(1'b0));
        chk("t4a_done",    256'(o_refill_done), 256'(1'b0));
        cyc();
        chk("t4a_done_later", 256'(o_refill_done), 256'(1'b0));

        // Miss accepted despite flush in IDLE; then flush in RESP after beat 1
        i_flush = 1'b1;
        start_miss(19'h0BEEF, 8'h77);
        i_flush = 1'b0;
        chk("t4b_accepted", 256'(o_mem_req_vld), 256'(1'b1));
        grant_req();
        beat(64'h55, 1'b0);
        beat(64'h66, 1'b0);
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        chk("t4b_busy", 256'(o_refill_busy), 256'(1'b1));
        beat(64'h77, 1'b0);
        beat(64'h88, 1'b0);
        chk("t4b_wren", 256'(o_dcache_wren), 256'(1'b0));
        chk("t4b_done", 256'(o_refill_done), 256'(1'b0));
        chk("t4b_busy_write", 256'(o_refill_busy), 256'(1'b1));
        cyc();
        chk("t4b_rdy", 256'(o_miss_rdy), 256'(1'b1));

        // Flush during the WRITE cycle suppresses the write
        start_miss(19'h00F0F, 8'h0F);
        grant_req();
        beat(64'h9, 1'b0); beat(64'hA, 1'b0); beat(64'hB, 1'b0); beat(64'hC, 1'b0);
        i_flush = 1'b1;
        #1;
        chk("t4c_wren", 256'(o_dcache_wren), 256'(1'b0));
        chk("t4c_done", 256'(o_refill_done), 256'(1'b0));
        cyc();
        i_flush = 1'b0;
        chk("t4c_rdy", 256'(o_miss_rdy), 256'(1'b1));

        // Back-to-back misses: second held during the first refill
        start_miss(19'h12345, 8'h10);
        chk("t5a_ridx", 256'(o_refill_idx), 256'(8'h10));
        i_miss_vld = 1'b1; i_miss_tag = 19'h54321; i_miss_idx = 8'h20;
        grant_req();
        beat(64'hAA, 1'b0); beat(64'hBB, 1'b0); beat(64'hCC, 1'b0); beat(64'hDD, 1'b0);
        chk("t5a_wren", 256'(o_dcache_wren), 256'(1'b1));
        chk("t5a_wtag", 256'(o_dcache_wtag), 256'(19'h12345));
        chk("t5a_widx", 256'(o_dcache_widx), 256'(8'h10));
        chk("t5a_rdy",  256'(o_miss_rdy), 256'(1'b0));
        cyc();
        chk("t5_idle_rdy", 256'(o_miss_rdy), 256'(1'b1));
        cyc();
        i_miss_vld = 1'b0;
        chk("t5b_req",  256'(o_mem_req_vld), 256'(1'b1));
        chk("t5b_addr", 256'(o_mem_req_addr), 256'(32'hA864_2400));
        chk("t5b_ridx", 256'(o_refill_idx), 256'(8'h20));
        grant_req();
        beat(64'h01, 1'b0); beat(64'h02, 1'b0); beat(64'h03, 1'b0); beat(64'h04, 1'b0);
        chk("t5b_wren", 256'(o_dcache_wren), 256'(1'b1));
        chk("t5b_wtag", 256'(o_dcache_wtag), 256'(19'h54321));
        chk("t5b_widx", 256'(o_dcache_widx), 256'(8'h20));
        chk("t5b_err",  256'(o_refill_err), 256'(1'b0));
        chk("t5b_wdat", o_dcache_wdat,
            256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
        cyc();

        // Reset mid-RESP, stray beats while reset is held
        start_miss(19'h3C3C3, 8'h99);
        grant_req();
        beat(64'hDEAD, 1'b0);
        beat(64'hBEEF, 1'b0);
        rst_n = 1'b0;
        cyc();
        chk("t6_rdy",     256'(o_miss_rdy), 256'(1'b1));
        chk("t6_busy",    256'(o_refill_busy), 256'(1'b0));
        chk("t6_req_vld", 256'(o_mem_req_vld), 256'(1'b0));
        chk("t6_addr",    256'(o_mem_req_addr), 256'(32'h0));
        chk("t6_ridx",    256'(o_refill_idx), 256'(8'h0));
        chk("t6_wdat",    o_dcache_wdat, 256'h0);
        beat(64'h1234, 1'b0);
        chk("t6_stray_wren0", 256'(o_dcache_wren), 256'(1'b0));
        beat(64'h5678, 1'b0);
        chk("t6_stray_wren1", 256'(o_dcache_wren), 256'(1'b0));
        rst_n = 1'b1;
        cyc();
        chk("t6_post_wren", 256'(o_dcache_wren), 256'(1'b0));
        chk("t6_post_done", 256'(o_refill_done), 256'(1'b0));
        chk("t6_post_rdy",  256'(o_miss_rdy), 256'(1'b1));
        chk("t6_post_wdat", o_dcache_wdat, 256'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
